jtag_master: RTL and testbench

JTAG_MASTER -- requirements
Module: jtag_master

---
 rtl/jtag_master_pkg.sv | 29 ++
 rtl/jtag_tck_gen.sv | 47 ++++
 rtl/jtag_master.sv | 178 +++++++++++++++++
 tb/tb_jtag_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: shared command codes, FSM states and TMS sequence lengths
// for the JTAG scan master.
package jtag_master_pkg;

  typedef enum logic [1:0] {
    CMD_DR  = 2'd0,
    CMD_IR  = 2'd1,
    CMD_RST = 2'd2,
    CMD_NOP = 2'd3
  } cmd_e;

  typedef enum logic [3:0] {
    IDLE,
    TRST,
    SEL_DR,
    SEL_IR,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE,
    RTI
  } state_e;

  localparam int DR_PRE_LEN = 3;
  localparam int IR_PRE_LEN = 4;
  localparam int SUF_LEN    = 2;
  localparam int RST_LEN    = 6;

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: tck = low phase then high phase while en, with rise/fall strobes.
// JTAG_MASTER_TCK_DIV_EN stretches each phase to div+1 clk cycles.
module jtag_tck_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
`ifdef JTAG_MASTER_TCK_DIV_EN
  input  logic [7:0] div,
`endif
  output logic       tck,
  output logic       rise,
  output logic       fall
);

  logic last;

`ifdef JTAG_MASTER_TCK_DIV_EN
  logic [7:0] cnt;

  assign last = (cnt == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!en || last)
      cnt <= '0;
    else
      cnt <= cnt + 8'd1;
  end
`else
  assign last = 1'b1;
`endif

  // Strobes flag the clk edge at which tck is about to toggle.
  assign rise = en & last & ~tck;
  assign fall = en & last & tck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tck <= 1'b0;
    else if (!en)
      tck <= 1'b0;
    else if (last)
      tck <= ~tck;
  end

endmodule

// File: rtl/jtag_master.sv
// jtag_master: JTAG scan master (DR scan, IR scan, TAP reset) for one TAP.
// Optional JTAG_MASTER_TCK_DIV_EN adds a tck_div input to slow tck.
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [5:0]        len,
  input  logic [DATA_W-1:0] data_in,
`ifdef JTAG_MASTER_TCK_DIV_EN
  input  logic [7:0]        tck_div,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q, state_n;
  cmd_e              cmd_q, cmd_n;
  logic [5:0]        len_q, len_n;
  logic [5:0]        cnt_q, cnt_n;
  logic [DATA_W-1:0] tx_q, tx_n;
  logic [DATA_W-1:0] rx_q, rx_n;
  logic [DATA_W-1:0] dout_n;
  logic              busy_n, done_n, tms_n, tdi_n;
  logic              rise, fall;

  jtag_tck_gen u_tck (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
`ifdef JTAG_MASTER_TCK_DIV_EN
    .div  (tck_div),
`endif
    .tck  (tck),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_NOP;
      len_q    <= '0;
      cnt_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
    end else begin
      state_q  <= state_n;
      cmd_q    <= cmd_n;
      len_q    <= len_n;
      cnt_q    <= cnt_n;
      tx_q     <= tx_n;
      rx_q     <= rx_n;
      data_out <= dout_n;
      busy     <= busy_n;
      done     <= done_n;
      tms      <= tms_n;
      tdi      <= tdi_n;
    end
  end

  // Each state is the TAP state the target sits in during the current
  // tck pulse; moves happen on the fall strobe ending that pulse.
  always_comb begin
    state_n = state_q;
    cmd_n   = cmd_q;
    len_n   = len_q;
    cnt_n   = cnt_q;
    tx_n    = tx_q;
    rx_n    = rx_q;
    dout_n  = data_out;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cmd_n = cmd_e'(cmd);
          len_n = (int'(len) > DATA_W) ? 6'(DATA_W) : len;
          tx_n  = data_in;
          rx_n  = '0;
          cnt_n = '0;
          if (cmd_n == CMD_NOP || len_n == 6'd0) begin
            done_n = 1'b1;
          end else begin
            busy_n  = 1'b1;
            state_n = (cmd_n == CMD_RST) ? TRST : RTI;
          end
        end
      end
      TRST: begin
        if (fall) begin
          if (cnt_q == 6'(RST_LEN - 1)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt_q + 6'd1;
          end
        end
      end
      RTI: begin
        if (fall) state_n = SEL_DR;
      end
      SEL_DR: begin
        if (fall) state_n = (cmd_q == CMD_IR) ? SEL_IR : CAPTURE;
      end
      SEL_IR: begin
        if (fall) state_n = CAPTURE;
      end
      CAPTURE: begin
        if (fall) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (rise) rx_n[cnt_q[IW-1:0]] = tdo;
        if (fall) begin
          tx_n = tx_q >> 1;
          if (cnt_q == len_q - 6'd1)
            state_n = EXIT1;
          else
            cnt_n = cnt_q + 6'd1;
        end
      end
      EXIT1: begin
        if (fall) state_n = UPDATE;
      end
      UPDATE: begin
        if (fall) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          dout_n  = rx_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pin values follow the next state, so they only move at start or tck fall.
  always_comb begin
    tms_n = 1'b1;
    tdi_n = 1'b0;
    unique case (state_n)
      IDLE:    tms_n = 1'b1;
      TRST:    tms_n = (cnt_n != 6'(RST_LEN - 1));
      RTI:     tms_n = 1'b1;
      SEL_DR:  tms_n = (cmd_n == CMD_IR);
      SEL_IR:  tms_n = 1'b0;
      CAPTURE: tms_n = 1'b0;
      SHIFT: begin
        tms_n = (cnt_n == len_n - 6'd1);
        tdi_n = tx_n[0];
      end
      EXIT1:   tms_n = 1'b1;
      UPDATE:  tms_n = 1'b0;
      default: tms_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: table vectors, random commands and reset-abort sequence
// checked against a pulse-level model of the JTAG command rules.
module tb_jtag_master;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   cmd;
  logic [5:0]   len;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         busy, done, tck, tms, tdi, tdo;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] resp, exp_dout;
  int           pfx;
  bit           prev_tck;
  bit           tms_q[$];
  bit           tdi_q[$];
  bit           exp_tms[$];
  bit           exp_tdi[$];

  typedef struct {
    logic [1:0]   c;
    logic [5:0]   l;
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [W-1:0] dout;
    int           pulses;
  } vec_t;

  vec_t tv[8];

  always #5 clk = ~clk;

  jtag_master #(.DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmd      (cmd),
    .len      (len),
    .data_in  (data_in),
`ifdef JTAG_MASTER_TCK_DIV_EN
    .tck_div  (8'd0),
`endif
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tdo      (tdo)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clk cycle; records each tck pulse and plays the target's TDO.
  task automatic step();
    int k;
    @(negedge clk);
    if (tck && !prev_tck) begin
      tms_q.push_back(tms);
      tdi_q.push_back(tdi);
    end
    prev_tck = tck;
    if (!tck) begin
      k = tms_q.size() - pfx;
      tdo = (k >= 0 && k < W) ? resp[k] : 1'b0;
    end
  endtask

  task automatic model(input logic [1:0] c, input int l,
                       input logic [W-1:0] d);
    int p;
    exp_tms.delete();
    exp_tdi.delete();
    if (c == 2'd3 || l == 0) return;
    if (c == 2'd2) begin
      exp_tms = '{1, 1, 1, 1, 1, 0};
      exp_tdi = '{0, 0, 0, 0, 0, 0};
      return;
    end
    p = (c == 2'd1) ? 4 : 3;
    exp_tms.push_back(1);
    if (c == 2'd1) exp_tms.push_back(1);
    exp_tms.push_back(0);
    exp_tms.push_back(0);
    for (int i = 0; i < l; i++) exp_tms.push_back(i == l - 1);
    exp_tms.push_back(1);
    exp_tms.push_back(0);
    for (int i = 0; i < exp_tms.size(); i++)
      exp_tdi.push_back((i >= p && i < p + l) ? d[i-p] : 1'b0);
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [5:0] lr,
                         input logic [W-1:0] d, input logic [W-1:0] r,
                         input bit poke);
    int l, cyc;
    bit act, hi, hold_bad;
    logic [63:0] tvv, dvv, etv, edv, mask;
    l = (int'(lr) > W) ? W : int'(lr);
    act = !(c == 2'd3 || l == 0);
    model(c, l, d);
    resp = r;
    pfx = (c == 2'd1) ? 4 : (c == 2'd0) ? 3 : 1000;
    tms_q.delete();
    tdi_q.delete();
    hold_bad = 0;
    hi = 0;
    start = 1'b1; cmd = c; len = lr; data_in = d;
    step();
    start = 1'b0;
    cmd = 2'($urandom);
    len = 6'($urandom);
    data_in = $urandom;
    cyc = 1;
    chk("busy_after_start", 64'(busy), 64'(act));
    while (!done && cyc < 2000) begin
      if (data_out !== exp_dout) hold_bad = 1;
      start = poke && act && cyc == 5;
      hi = tck;
      step();
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    if (!act) chk("nop_done_cycle", 64'(cyc), 64'd1);
    else chk("tck_high_before_done", 64'(hi), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("tck_idle", 64'(tck), 64'd0);
    chk("tdi_idle", 64'(tdi), 64'd0);
    chk("dout_hold", 64'(hold_bad), 64'd0);
    chk("pulses", 64'(tms_q.size()), 64'(exp_tms.size()));
    tvv = '0; dvv = '0; etv = '0; edv = '0;
    for (int i = 0; i < tms_q.size() && i < 64; i++) begin
      tvv[i] = tms_q[i];
      dvv[i] = tdi_q[i];
    end
    for (int i = 0; i < exp_tms.size(); i++) begin
      etv[i] = exp_tms[i];
      edv[i] = exp_tdi[i];
    end
    chk("tms_seq", tvv, etv);
    chk("tdi_seq", dvv, edv);
    if (act && c != 2'd2) begin
      mask = (64'd1 << l) - 64'd1;
      exp_dout = r & mask[W-1:0];
    end
    chk("data_out", 64'(data_out), 64'(exp_dout));
    step();
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit bad;
    logic [63:0] pv;
    tv[0] = '{2'd0, 6'd32, 32'hCAFEF00D, 32'h12345678, 32'h12345678, 37};
    tv[1] = '{2'd1, 6'd4,  32'h00000002, 32'h0000000A, 32'h0000000A, 10};
    tv[2] = '{2'd0, 6'd1,  32'h00000001, 32'h00000001, 32'h00000001, 6};
    tv[3] = '{2'd0, 6'd32, 32'h00000000, 32'hA5A5A5A5, 32'hA5A5A5A5, 37};
    tv[4] = '{2'd2, 6'd5,  32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 6};
    tv[5] = '{2'd0, 6'd0,  32'h0000FFFF, 32'h11111111, 32'hA5A5A5A5, 0};
    tv[6] = '{2'd0, 6'd40, 32'h0F0F0F0F, 32'h87654321, 32'h87654321, 37};
    tv[7] = '{2'd3, 6'd8,  32'h000000FF, 32'h22222222, 32'h87654321, 0};

    rst = 1'b1; start = 1'b0; cmd = '0; len = '0; data_in = '0;
    tdo = 1'b0; resp = '0; pfx = 1000; prev_tck = 0; exp_dout = '0;
    #1;
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_cmd(tv[i].c, tv[i].l, tv[i].d, tv[i].r, i == 0);
      chk("tv_data_out", 64'(data_out), 64'(tv[i].dout));
      chk("tv_pulses", 64'(tms_q.size()), 64'(tv[i].pulses));
    end

    for (int n = 0; n < 40; n++)
      run_cmd(2'($urandom_range(0, 3)), 6'($urandom), $urandom, $urandom,
              1'($urandom_range(0, 1)));

    // Abort a DR scan at shift bit 10 after a start pulse while busy.
    resp = $urandom;
    pfx = 3;
    tms_q.delete();
    tdi_q.delete();
    start = 1'b1; cmd = 2'd0; len = 6'd32; data_in = $urandom;
    step();
    cyc = 0;
    while (tms_q.size() < 14 && cyc < 500) begin
      start = (cyc == 3);
      cmd = 2'd2;
      step();
      cyc++;
    end
    start = 1'b0;
    chk("abort_reached_bit10", 64'(tms_q.size()), 64'd14);
    pv = '0;
    for (int i = 0; i < tms_q.size() && i < 64; i++) pv[i] = tms_q[i];
    chk("abort_tms_prefix", pv, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_tck", 64'(tck), 64'd0);
    chk("abort_tms", 64'(tms), 64'd1);
    chk("abort_tdi", 64'(tdi), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_data_out", 64'(data_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_dout = '0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) bad = 1;
    end
    chk("no_done_after_abort", 64'(bad), 64'd0);
    run_cmd(2'd0, 6'd32, $urandom, 32'h12345678, 1'b0);
    chk("post_abort_data_out", 64'(data_out), 64'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
